// File: rtl/acs_array.sv
// rtl/acs_array.sv - add-compare-select array for a rate-1/2 Viterbi decoder
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   bm, bm_valid, start four branch metrics (slice j = symbol {c0,c1}), step strobe, frame start
//   dec                 survivor decision per next-state (1 = predecessor with LSB 1)
//   best_state          index of the smallest path metric after the step
//   out_valid           one-cycle pulse marking dec/best_state of one step
module acs_array #(
    parameter int K        = 7,
    parameter int G0       = 'o133,
    parameter int G1       = 'o171,
    parameter int BM_WIDTH = 9,
    parameter int PM_WIDTH = 12,
    parameter int INIT_PM  = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*BM_WIDTH-1:0] bm,
    input  logic                  bm_valid,
    input  logic                  start,
    output logic [(1<<(K-1))-1:0] dec,
    output logic [K-2:0]          best_state,
    output logic                  out_valid
);
    localparam int N  = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam logic [PM_WIDTH-1:0] PM_INIT = PM_WIDTH'(INIT_PM);
    localparam logic [PM_WIDTH-1:0] PM_HALF = {1'b1, {(PM_WIDTH-1){1'b0}}};

    // Symbol index {c0,c1} for the branch into ns from the predecessor whose LSB is x.
    // The encoder register for that branch is {ns, x}.
    function automatic logic [1:0] sym_of(input int ns, input int x);
        logic [K-1:0] enc;
        logic [K-1:0] g0v;
        logic [K-1:0] g1v;
        enc = K'((ns << 1) | x);
        g0v = K'(G0);
        g1v = K'(G1);
        return {^(enc & g0v), ^(enc & g1v)};
    endfunction

    // stage 0
    logic [4*BM_WIDTH-1:0] bm_q, bm_d;
    logic                  v0_q, v0_d;
    logic                  st0_q, st0_d;
    // stage 1
    logic [PM_WIDTH-1:0]   pm_q [N];
    logic [PM_WIDTH-1:0]   pm_d [N];
    logic                  norm_q, norm_d;
    logic [N-1:0]          dsel_q, dsel_d;
    logic                  v1_q, v1_d;
    // stage 2
    logic [N-1:0]          dec_q, dec_d;
    logic [SW-1:0]         best_q, best_d;
    logic                  ov_q, ov_d;

    logic [PM_WIDTH-1:0]   pm_src [N];
    logic [PM_WIDTH-1:0]   cand0 [N];
    logic [PM_WIDTH-1:0]   cand1 [N];
    logic [PM_WIDTH-1:0]   nsub;
    logic [SW-1:0]         p0_idx;
    logic                  msb_all;
    logic [PM_WIDTH-1:0]   best_val;

    always_comb begin
        bm_d  = bm_valid ? bm : bm_q;
        v0_d  = bm_valid;
        st0_d = bm_valid & start;
    end

    always_comb begin
        // A frame start replaces the stored metrics, so any pending normalisation is dropped.
        nsub    = (norm_q && !st0_q) ? PM_HALF : '0;
        p0_idx  = '0;
        msb_all = 1'b1;
        dsel_d  = dsel_q;
        for (int s = 0; s < N; s++) begin
            pm_src[s] = st0_q ? ((s == 0) ? '0 : PM_INIT) : pm_q[s];
        end
        for (int ns = 0; ns < N; ns++) begin
            p0_idx    = SW'(ns << 1);
            cand0[ns] = pm_src[p0_idx] - nsub
                      + PM_WIDTH'(bm_q[int'(sym_of(ns, 0)) * BM_WIDTH +: BM_WIDTH]);
            cand1[ns] = pm_src[p0_idx | SW'(1)] - nsub
                      + PM_WIDTH'(bm_q[int'(sym_of(ns, 1)) * BM_WIDTH +: BM_WIDTH]);
            if (v0_q) begin
                // Ties keep predecessor p0.
                dsel_d[ns] = (cand1[ns] < cand0[ns]);
                pm_d[ns]   = (cand1[ns] < cand0[ns]) ? cand1[ns] : cand0[ns];
            end else begin
                pm_d[ns] = pm_q[ns];
            end
            msb_all = msb_all & pm_d[ns][PM_WIDTH-1];
        end
        norm_d = v0_q ? msb_all : norm_q;
        v1_d   = v0_q;
    end

    always_comb begin
        // Strict compare so the lowest index wins a tie.
        best_val = pm_q[0];
        best_d   = '0;
        for (int s = 1; s < N; s++) begin
            if (pm_q[s] < best_val) begin
                best_val = pm_q[s];
                best_d   = SW'(s);
            end
        end
        if (!v1_q) begin
            best_d = best_q;
        end
        dec_d = v1_q ? dsel_q : dec_q;
        ov_d  = v1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bm_q   <= '0;
            v0_q   <= 1'b0;
            st0_q  <= 1'b0;
            norm_q <= 1'b0;
            dsel_q <= '0;
            v1_q   <= 1'b0;
            dec_q  <= '0;
            best_q <= '0;
            ov_q   <= 1'b0;
            for (int s = 0; s < N; s++) begin
                pm_q[s] <= (s == 0) ? '0 : PM_INIT;
            end
        end else begin
            bm_q   <= bm_d;
            v0_q   <= v0_d;
            st0_q  <= st0_d;
            norm_q <= norm_d;
            dsel_q <= dsel_d;
            v1_q   <= v1_d;
            dec_q  <= dec_d;
            best_q <= best_d;
            ov_q   <= ov_d;
            for (int s = 0; s < N; s++) begin
                pm_q[s] <= pm_d[s];
            end
        end
    end

    assign dec        = dec_q;
    assign best_state = best_q;
    assign out_valid  = ov_q;

endmodule

// File: tb/tb_acs_array.sv
// tb/tb_acs_array.sv - scoreboard bench for acs_array, K=7 and K=5 instances
module tb_acs_array;
    localparam int BMW  = 9;
    localparam int INIT = 256;

    typedef struct {
        int          due;
        logic [63:0] dec;
        int          best;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [4*BMW-1:0] bm7, bm5;
    logic             v7, st7, v5, st5;
    logic [63:0]      dec7;
    logic [5:0]       best7;
    logic             ov7;
    logic [15:0]      dec5;
    logic [3:0]       best5;
    logic             ov5;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q7[$];
    exp_t q5[$];

    int          gpm[64];
    int          m_k  = 7;
    int          m_g0 = 'o133;
    int          m_g1 = 'o171;
    logic [63:0] m_dec;
    int          m_best;

    int bits[7]     = '{1, 0, 1, 1, 0, 0, 1};
    int best_tab[7] = '{32, 16, 40, 52, 26, 13, 38};

    always #5 clock = ~clock;

    acs_array #(.K(7), .G0('o133), .G1('o171), .BM_WIDTH(BMW), .PM_WIDTH(12), .INIT_PM(INIT)) u7 (
        .clock(clock), .reset(reset), .bm(bm7), .bm_valid(v7), .start(st7),
        .dec(dec7), .best_state(best7), .out_valid(ov7)
    );

    acs_array #(.K(5), .G0('o23), .G1('o35), .BM_WIDTH(BMW), .PM_WIDTH(12), .INIT_PM(INIT)) u5 (
        .clock(clock), .reset(reset), .bm(bm5), .bm_valid(v5), .start(st5),
        .dec(dec5), .best_state(best5), .out_valid(ov5)
    );

    function automatic int par(input int v);
        int r = 0;
        for (int i = 0; i < 12; i++) r ^= (v >> i) & 1;
        return r;
    endfunction

    task automatic set_cfg(input int k, input int g0, input int g1);
        m_k = k; m_g0 = g0; m_g1 = g1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) gpm[i] = (i == 0) ? 0 : INIT;
    endtask

    // Forward trellis walk with unbounded integer metrics.
    task automatic model_step(input int bv[4], input bit st);
        int c[64][2];
        int n, ns, r, sym;
        n = 1 << (m_k - 1);
        if (st) model_reset();
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < 2; b++) begin
                ns  = (b << (m_k - 2)) | (p >> 1);
                r   = (b << (m_k - 1)) | p;
                sym = 2 * par(r & m_g0) + par(r & m_g1);
                c[ns][p & 1] = gpm[p] + bv[sym];
            end
        end
        m_dec  = '0;
        m_best = 0;
        for (int s = 0; s < n; s++) begin
            if (c[s][1] < c[s][0]) begin
                gpm[s]   = c[s][1];
                m_dec[s] = 1'b1;
            end else begin
                gpm[s] = c[s][0];
            end
        end
        for (int s = 1; s < n; s++) if (gpm[s] < gpm[m_best]) m_best = s;
    endtask

    task automatic check_dut(input bit is5);
        exp_t        e;
        logic        exp_v;
        logic        ov;
        logic [63:0] od;
        logic [31:0] ob;
        int          kk;
        kk = is5 ? 5 : 7;
        ov = is5 ? ov5 : ov7;
        od = is5 ? {48'b0, dec5} : dec7;
        ob = is5 ? {28'b0, best5} : {26'b0, best7};
        if (is5) exp_v = (q5.size() > 0) && (q5[0].due == cyc);
        else     exp_v = (q7.size() > 0) && (q7[0].due == cyc);
        total++;
        assert (ov === exp_v) else begin
            bad++;
            $error("FAIL out_valid k%0d cyc=%0d observed=%b expected=%b", kk, cyc, ov, exp_v);
        end
        if (exp_v) begin
            if (is5) e = q5.pop_front();
            else     e = q7.pop_front();
            total++;
            assert (od === e.dec) else begin
                bad++;
                $error("FAIL dec k%0d cyc=%0d observed=%h expected=%h", kk, cyc, od, e.dec);
            end
            total++;
            assert (ob === e.best) else begin
                bad++;
                $error("FAIL best_state k%0d cyc=%0d observed=%0d expected=%0d", kk, cyc, ob, e.best);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        check_dut(1'b0);
        check_dut(1'b1);
    endtask

    // Drives one cycle of inputs; a valid step is modelled and its result queued for
    // the pulse two edges after the sampling edge.
    task automatic step_in(input bit on5, input int bv[4], input bit v, input bit st, input int exp_best);
        logic [4*BMW-1:0] pb;
        exp_t             e;
        for (int j = 0; j < 4; j++) pb[j*BMW +: BMW] = BMW'(bv[j]);
        if (on5) begin bm5 = pb; v5 = v; st5 = st; end
        else     begin bm7 = pb; v7 = v; st7 = st; end
        if (v) begin
            model_step(bv, st);
            e.due  = cyc + 3;
            e.dec  = m_dec;
            e.best = (exp_best >= 0) ? exp_best : m_best;
            if (on5) q5.push_back(e);
            else     q7.push_back(e);
        end
        tick();
        v5 = 1'b0; st5 = 1'b0; v7 = 1'b0; st7 = 1'b0;
    endtask

    task automatic idle_cycle(input bit on5);
        int bv[4];
        for (int j = 0; j < 4; j++) bv[j] = $urandom_range(0, 511);
        step_in(on5, bv, 1'b0, 1'($urandom_range(0, 1)), -1);
    endtask

    task automatic run_noiseless(input bit on5, input bit first_start, input bit gaps,
                                 input bit use_table, input int n);
        int bv[4];
        int es, b, r, sym;
        es = 0;
        for (int i = 0; i < n; i++) begin
            b   = bits[i];
            r   = (b << (m_k - 1)) | es;
            sym = 2 * par(r & m_g0) + par(r & m_g1);
            for (int j = 0; j < 4; j++) bv[j] = (j == sym) ? 0 : 8;
            es  = (b << (m_k - 2)) | (es >> 1);
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle(on5);
            step_in(on5, bv, 1'b1, first_start && (i == 0), use_table ? best_tab[i] : -1);
        end
    endtask

    initial begin
        int bv[4];
        reset = 1'b1;
        bm7 = '0; bm5 = '0; v7 = 1'b0; st7 = 1'b0; v5 = 1'b0; st5 = 1'b0;
        model_reset();
        repeat (2) tick();
        total++; assert (dec7 === 64'd0) else begin bad++; $error("FAIL reset_dec7 observed=%h expected=0", dec7); end
        total++; assert (best7 === 6'd0) else begin bad++; $error("FAIL reset_best7 observed=%0d expected=0", best7); end
        total++; assert (dec5 === 16'd0) else begin bad++; $error("FAIL reset_dec5 observed=%h expected=0", dec5); end
        total++; assert (best5 === 4'd0) else begin bad++; $error("FAIL reset_best5 observed=%0d expected=0", best5); end
        reset = 1'b0;
        repeat (3) tick();

        // all-zero codeword: symbol 00 costs 0
        set_cfg(7, 'o133, 'o171);
        bv = '{0, 8, 8, 8};
        for (int i = 0; i < 20; i++) step_in(1'b0, bv, 1'b1, i == 0, 0);
        repeat (3) tick();

        // noiseless known sequence, contiguous
        run_noiseless(1'b0, 1'b1, 1'b0, 1'b1, 7);
        repeat (3) tick();

        // same stream with gaps, then a second start mid-stream
        run_noiseless(1'b0, 1'b1, 1'b1, 1'b1, 7);
        run_noiseless(1'b0, 1'b1, 1'b1, 1'b1, 7);
        repeat (3) tick();

        // reset mid-frame with steps in flight
        run_noiseless(1'b0, 1'b1, 1'b0, 1'b1, 4);
        reset = 1'b1;
        #1;
        total++; assert (ov7 === 1'b0) else begin bad++; $error("FAIL midreset_ov observed=%b expected=0", ov7); end
        total++; assert (dec7 === 64'd0) else begin bad++; $error("FAIL midreset_dec observed=%h expected=0", dec7); end
        total++; assert (best7 === 6'd0) else begin bad++; $error("FAIL midreset_best observed=%0d expected=0", best7); end
        q7.delete();
        model_reset();
        tick();
        reset = 1'b0;
        repeat (4) idle_cycle(1'b0);
        // first frame after release, no start: reset metrics apply
        run_noiseless(1'b0, 1'b0, 1'b0, 1'b1, 7);
        repeat (3) tick();

        // normalisation: uniform growth, then small random metrics
        bv = '{255, 255, 255, 255};
        for (int i = 0; i < 300; i++) step_in(1'b0, bv, 1'b1, i == 0, -1);
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 4; j++) bv[j] = $urandom_range(0, 63);
            step_in(1'b0, bv, 1'b1, 1'b0, -1);
        end
        repeat (3) tick();

        // K=5 instance
        set_cfg(5, 'o23, 'o35);
        model_reset();
        run_noiseless(1'b1, 1'b1, 1'b0, 1'b0, 7);
        run_noiseless(1'b1, 1'b1, 1'b1, 1'b0, 7);

        repeat (6) tick();
        total++;
        assert ((q7.size() == 0) && (q5.size() == 0)) else begin
            bad++;
            $error("FAIL drain observed=%0d/%0d pending expected=0", q7.size(), q5.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
